// File: rtl/axi_tlb_l1.sv
// L1 range-based address translation: NumEntries page ranges, NumChannels independent 1-cycle lookups.
// Optional saturating hit/miss counters are built when AXI_TLB_L1_PERF_CNT_EN is defined.
module axi_tlb_l1 #(
  parameter int unsigned InpAddrWidth = 48,
  parameter int unsigned OupAddrWidth = 48,
  parameter int unsigned NumEntries   = 16,
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned CntWidth     = 32,
  localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                bypass_i,
  input  logic                                cfg_we_i,
  input  logic [IdxW-1:0]                     cfg_idx_i,
  input  logic [InpAddrWidth-13:0]            cfg_first_i,
  input  logic [InpAddrWidth-13:0]            cfg_last_i,
  input  logic [OupAddrWidth-13:0]            cfg_base_i,
  input  logic                                cfg_valid_i,
  input  logic                                cfg_ro_i,
  input  logic                                cfg_flush_i,
  input  logic [NumChannels-1:0]              req_valid_i,
  output logic [NumChannels-1:0]              req_ready_o,
  input  logic [NumChannels*InpAddrWidth-1:0] req_addr_i,
  input  logic [NumChannels-1:0]              req_write_i,
  output logic [NumChannels-1:0]              rsp_valid_o,
  input  logic [NumChannels-1:0]              rsp_ready_i,
  output logic [NumChannels*OupAddrWidth-1:0] rsp_addr_o,
  output logic [NumChannels-1:0]              rsp_hit_o,
  output logic [NumChannels-1:0]              rsp_err_o,
  output logic [NumChannels*CntWidth-1:0]     hit_cnt_o,
  output logic [NumChannels*CntWidth-1:0]     miss_cnt_o
);

  localparam int unsigned IPW = InpAddrWidth - 12;
  localparam int unsigned OPW = OupAddrWidth - 12;
  localparam int unsigned MW  = (IPW > OPW) ? IPW : OPW;

  logic [IPW-1:0]        first_q [NumEntries];
  logic [IPW-1:0]        last_q  [NumEntries];
  logic [OPW-1:0]        base_q  [NumEntries];
  logic [NumEntries-1:0] valid_q;
  logic [NumEntries-1:0] ro_q;
  logic                  cfg_idx_ok;

  assign cfg_idx_ok = (32'(cfg_idx_i) < NumEntries);

  // Flush clears first; a same-cycle write then lands on top with its own valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumEntries; i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
        base_q[i]  <= '0;
      end
      valid_q <= '0;
      ro_q    <= '0;
    end else begin
      if (cfg_flush_i) valid_q <= '0;
      if (cfg_we_i && cfg_idx_ok) begin
        first_q[cfg_idx_i] <= cfg_first_i;
        last_q[cfg_idx_i]  <= cfg_last_i;
        base_q[cfg_idx_i]  <= cfg_base_i;
        valid_q[cfg_idx_i] <= cfg_valid_i;
        ro_q[cfg_idx_i]    <= cfg_ro_i;
      end
    end
  end

  logic [OupAddrWidth-1:0] rsp_addr_d [NumChannels];
  logic [NumChannels-1:0]  rsp_hit_d;
  logic [NumChannels-1:0]  rsp_err_d;
  logic [IPW-1:0]          page;
  logic [11:0]             offs;

  always_comb begin
    page = '0;
    offs = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      page          = req_addr_i[c*InpAddrWidth+12 +: IPW];
      offs          = req_addr_i[c*InpAddrWidth +: 12];
      rsp_addr_d[c] = '0;
      rsp_hit_d[c]  = 1'b0;
      rsp_err_d[c]  = 1'b1;
      // Descending scan: the lowest matching index is the last assignment and wins.
      for (int unsigned i = NumEntries; i > 0; i--) begin
        if (valid_q[i-1] && (first_q[i-1] <= page) && (page <= last_q[i-1])) begin
          rsp_addr_d[c] = {OPW'(MW'(base_q[i-1]) + MW'(page) - MW'(first_q[i-1])), offs};
          rsp_hit_d[c]  = 1'b1;
          rsp_err_d[c]  = req_write_i[c] & ro_q[i-1];
        end
      end
      if (bypass_i) begin
        rsp_addr_d[c] = OupAddrWidth'(req_addr_i[c*InpAddrWidth +: InpAddrWidth]);
        rsp_hit_d[c]  = 1'b1;
        rsp_err_d[c]  = 1'b0;
      end
    end
  end

  logic [NumChannels-1:0]  rsp_valid_q;
  logic [NumChannels-1:0]  rsp_hit_q;
  logic [NumChannels-1:0]  rsp_err_q;
  logic [OupAddrWidth-1:0] rsp_addr_q [NumChannels];
  logic [NumChannels-1:0]  acc;

  assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
  assign acc         = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_hit_q   <= '0;
      rsp_err_q   <= '0;
      for (int unsigned c = 0; c < NumChannels; c++) rsp_addr_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        if (acc[c]) begin
          rsp_valid_q[c] <= 1'b1;
          rsp_addr_q[c]  <= rsp_addr_d[c];
          rsp_hit_q[c]   <= rsp_hit_d[c];
          rsp_err_q[c]   <= rsp_err_d[c];
        end else if (rsp_ready_i[c]) begin
          rsp_valid_q[c] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_err_o   = rsp_err_q;

  always_comb begin
    rsp_addr_o = '0;
    for (int unsigned c = 0; c < NumChannels; c++) rsp_addr_o[c*OupAddrWidth +: OupAddrWidth] = rsp_addr_q[c];
  end

`ifdef AXI_TLB_L1_PERF_CNT_EN
  logic [CntWidth-1:0] hit_cnt_q  [NumChannels];
  logic [CntWidth-1:0] miss_cnt_q [NumChannels];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        hit_cnt_q[c]  <= '0;
        miss_cnt_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        if (acc[c] && !bypass_i) begin
          if (rsp_hit_d[c]) begin
            if (hit_cnt_q[c] != '1) hit_cnt_q[c] <= hit_cnt_q[c] + 1'b1;
          end else begin
            if (miss_cnt_q[c] != '1) miss_cnt_q[c] <= miss_cnt_q[c] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    hit_cnt_o  = '0;
    miss_cnt_o = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      hit_cnt_o[c*CntWidth +: CntWidth]  = hit_cnt_q[c];
      miss_cnt_o[c*CntWidth +: CntWidth] = miss_cnt_q[c];
    end
  end
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_tlb_l1.sv
// Bench for axi_tlb_l1: directed scenarios plus random traffic against a range-table reference model.
module tb_axi_tlb_l1;
  localparam int NE = 6;
  localparam int NC = 2;
  localparam int AW = 48;
  localparam int PW = 36;
  localparam int CW = 4;
`ifdef AXI_TLB_L1_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk, rst, bypass, cfg_we, cfg_valid, cfg_ro, cfg_flush;
  logic [2:0]    cfg_idx;
  logic [PW-1:0] cfg_first, cfg_last, cfg_base;
  logic [NC-1:0] req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [NC*AW-1:0] req_addr, rsp_addr;
  logic [NC*CW-1:0] hit_cnt, miss_cnt;

  axi_tlb_l1 #(.InpAddrWidth(AW), .OupAddrWidth(AW), .NumEntries(NE), .NumChannels(NC), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst), .bypass_i(bypass),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_first_i(cfg_first), .cfg_last_i(cfg_last),
    .cfg_base_i(cfg_base), .cfg_valid_i(cfg_valid), .cfg_ro_i(cfg_ro), .cfg_flush_i(cfg_flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_write_i(req_write),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_addr_o(rsp_addr),
    .rsp_hit_o(rsp_hit), .rsp_err_o(rsp_err), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the page table as plain arrays plus the expected response per channel.
  logic [PW-1:0] m_first [NE];
  logic [PW-1:0] m_last  [NE];
  logic [PW-1:0] m_base  [NE];
  bit            m_valid [NE];
  bit            m_ro    [NE];
  bit            e_v [NC];
  bit            e_hit [NC];
  bit            e_err [NC];
  logic [AW-1:0] e_addr [NC];
  int            e_hc [NC];
  int            e_mc [NC];
  int            n_checks, n_fail;

  function automatic void lookup(input logic [AW-1:0] a, input bit w, input bit byp,
                                 output logic [AW-1:0] o, output bit h, output bit e);
    logic [PW-1:0] p;
    o = '0; h = 1'b0; e = 1'b1;
    if (byp) begin o = a; h = 1'b1; e = 1'b0; return; end
    p = a[AW-1:12];
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && m_first[i] <= p && p <= m_last[i]) begin
        o = {m_base[i] + (p - m_first[i]), a[11:0]};
        h = 1'b1;
        e = w && m_ro[i];
        return;
      end
    end
  endfunction

  task automatic step();
    bit acc [NC];
    bit rdy [NC];
    bit ph [NC];
    bit pe [NC];
    logic [AW-1:0] pa [NC];
    bit byp, r;
    byp = bypass; r = rst;
    for (int c = 0; c < NC; c++) begin
      rdy[c] = rsp_ready[c];
      acc[c] = req_valid[c] && (!e_v[c] || rsp_ready[c]);
      lookup(req_addr[c*AW +: AW], req_write[c], byp, pa[c], ph[c], pe[c]);
    end
    if (cfg_flush) for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    if (cfg_we && int'(cfg_idx) < NE) begin
      m_first[cfg_idx] = cfg_first; m_last[cfg_idx] = cfg_last; m_base[cfg_idx] = cfg_base;
      m_valid[cfg_idx] = cfg_valid; m_ro[cfg_idx] = cfg_ro;
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NE; i++) begin
        m_first[i] = '0; m_last[i] = '0; m_base[i] = '0; m_valid[i] = 1'b0; m_ro[i] = 1'b0;
      end
      for (int c = 0; c < NC; c++) begin
        e_v[c] = 1'b0; e_hit[c] = 1'b0; e_err[c] = 1'b0; e_addr[c] = '0; e_hc[c] = 0; e_mc[c] = 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (acc[c]) begin
          e_v[c] = 1'b1; e_addr[c] = pa[c]; e_hit[c] = ph[c]; e_err[c] = pe[c];
          if (!byp) begin
            if (ph[c]) e_hc[c] = (e_hc[c] < 15) ? e_hc[c] + 1 : 15;
            else       e_mc[c] = (e_mc[c] < 15) ? e_mc[c] + 1 : 15;
          end
        end else if (rdy[c]) begin
          e_v[c] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    bypass = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_first = '0; cfg_last = '0; cfg_base = '0;
    cfg_valid = 1'b0; cfg_ro = 1'b0; cfg_flush = 1'b0;
    req_valid = '0; req_addr = '0; req_write = '0; rsp_ready = '1;
  endtask

  task automatic cfg_write(input int idx, input logic [PW-1:0] f, input logic [PW-1:0] l,
                           input logic [PW-1:0] b, input bit v, input bit ro);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_first = f; cfg_last = l; cfg_base = b;
    cfg_valid = v; cfg_ro = ro;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; req_valid = '1; req_addr = {48'h0000_0010_0000, 48'h0000_0020_0000};
    step(); step();
    rst = 1'b0; req_valid = '0;
    #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", rsp_valid); end
    n_checks++; if (rsp_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", rsp_addr); end
    n_checks++; if ({rsp_hit, rsp_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {rsp_hit, rsp_err}); end
    n_checks++; if ({hit_cnt, miss_cnt} !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", {hit_cnt, miss_cnt}); end
    n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", req_ready); end
  endtask

  task automatic test_miss();
    req_valid = 2'b01; req_addr[47:0] = 48'h0000_1234_5678; req_write = '0;
    step();
    req_valid = '0;
    n_checks++; if ({rsp_valid[0], rsp_hit[0], rsp_err[0], rsp_addr[47:0]} !== {3'b101, 48'h0})
      begin n_fail++; $display("FAIL miss_rsp: got %b/%h want 101/0", {rsp_valid[0], rsp_hit[0], rsp_err[0]}, rsp_addr[47:0]); end
    n_checks++; if (miss_cnt[3:0] !== (PERF ? 4'd1 : 4'd0))
      begin n_fail++; $display("FAIL miss_cnt: got %0d want %0d", miss_cnt[3:0], PERF ? 1 : 0); end
    step();
  endtask

  task automatic test_translate();
    cfg_write(3, 36'h100, 36'h1FF, 36'h8000, 1'b1, 1'b0);
    req_valid = 2'b01; req_addr[47:0] = 48'h0000_0015_0ABC; req_write = '0;
    #1;
    n_checks++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL xlat_early: got %b want 0", rsp_valid[0]); end
    step();
    req_valid = '0;
    n_checks++; if ({rsp_valid[0], rsp_hit[0], rsp_err[0], rsp_addr[47:0]} !== {3'b110, 48'h0000_0805_0ABC})
      begin n_fail++; $display("FAIL xlat_rsp: got %b/%h want 110/000008050abc", {rsp_valid[0], rsp_hit[0], rsp_err[0]}, rsp_addr[47:0]); end
    step();
  endtask

  task automatic test_priority();
    cfg_flush = 1'b1; step(); cfg_flush = 1'b0;
    cfg_write(2, 36'h100, 36'h1FF, 36'h1000, 1'b1, 1'b0);
    cfg_write(5, 36'h150, 36'h150, 36'h2000, 1'b1, 1'b0);
    req_valid = 2'b10; req_addr[95:48] = 48'h0000_0015_0123; req_write = 2'b00;
    step();
    req_valid = '0;
    n_checks++; if ({rsp_valid[1], rsp_hit[1], rsp_err[1], rsp_addr[95:48]} !== {3'b110, 48'h0000_0105_0123})
      begin n_fail++; $display("FAIL prio_rsp: got %b/%h want 110/000001050123", {rsp_valid[1], rsp_hit[1], rsp_err[1]}, rsp_addr[95:48]); end
    cfg_write(2, 36'h100, 36'h1FF, 36'h1000, 1'b1, 1'b1);
    req_valid = 2'b10; req_write = 2'b10;
    step();
    req_valid = '0; req_write = '0;
    n_checks++; if ({rsp_valid[1], rsp_hit[1], rsp_err[1], rsp_addr[95:48]} !== {3'b111, 48'h0000_0105_0123})
      begin n_fail++; $display("FAIL ro_write: got %b/%h want 111/000001050123", {rsp_valid[1], rsp_hit[1], rsp_err[1]}, rsp_addr[95:48]); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW+2:0] held;
    rsp_ready = 2'b01; req_valid = 2'b11;
    for (int c = 0; c < NC; c++) req_addr[c*AW +: AW] = {12'h0, 24'($urandom_range(16'h100, 16'h1FF)), 12'($urandom)};
    req_write = 2'($urandom);
    step();
    held = {rsp_valid[1], rsp_hit[1], rsp_err[1], rsp_addr[95:48]};
    n_checks++; if (held !== {1'b1, e_hit[1], e_err[1], e_addr[1]})
      begin n_fail++; $display("FAIL b2b_first: got %h want %h", held, {1'b1, e_hit[1], e_err[1], e_addr[1]}); end
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < NC; c++) req_addr[c*AW +: AW] = {12'h0, 24'($urandom_range(16'h100, 16'h1FF)), 12'($urandom)};
      req_write = 2'($urandom);
      if (k == 2) begin
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_first = 36'h100; cfg_last = 36'h1FF; cfg_base = 36'h3333;
        cfg_valid = 1'b1; cfg_ro = 1'b0;
      end
      #1;
      n_checks++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready1 k%0d: got %b want 0", k, req_ready[1]); end
      n_checks++; if ({rsp_valid[1], rsp_hit[1], rsp_err[1], rsp_addr[95:48]} !== held)
        begin n_fail++; $display("FAIL b2b_hold k%0d: got %h want %h", k, {rsp_valid[1], rsp_hit[1], rsp_err[1], rsp_addr[95:48]}, held); end
      step();
      cfg_we = 1'b0;
      n_checks++; if ({rsp_valid[0], rsp_hit[0], rsp_err[0], rsp_addr[47:0]} !== {1'b1, e_hit[0], e_err[0], e_addr[0]})
        begin n_fail++; $display("FAIL b2b_ch0 k%0d: got %h want %h", k, {rsp_valid[0], rsp_hit[0], rsp_err[0], rsp_addr[47:0]}, {1'b1, e_hit[0], e_err[0], e_addr[0]}); end
    end
    req_valid = '0; rsp_ready = 2'b11;
    #1;
    n_checks++; if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_release: got %b want 1", req_ready[1]); end
    step();
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_drain: got %b want 00", rsp_valid); end
  endtask

  task automatic test_flush_write();
    cfg_write(4, 36'h300, 36'h3FF, 36'h4000, 1'b1, 1'b0);
    cfg_write(1, 36'h600, 36'h6FF, 36'h7000, 1'b1, 1'b0);
    cfg_flush = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_first = 36'h500; cfg_last = 36'h5FF;
    cfg_base = 36'h6000; cfg_valid = 1'b1; cfg_ro = 1'b0;
    req_valid = 2'b01; req_addr[47:0] = 48'h0000_0031_0456;
    step();
    cfg_flush = 1'b0; cfg_we = 1'b0;
    n_checks++; if ({rsp_hit[0], rsp_err[0], rsp_addr[47:0]} !== {2'b10, 48'h0000_0401_0456})
      begin n_fail++; $display("FAIL fw_same: got %b/%h want 10/000004010456", {rsp_hit[0], rsp_err[0]}, rsp_addr[47:0]); end
    req_valid = 2'b11; req_addr = {48'h0000_0051_0789, 48'h0000_0031_0456};
    step();
    n_checks++; if ({rsp_hit[0], rsp_err[0], rsp_addr[47:0]} !== {2'b01, 48'h0})
      begin n_fail++; $display("FAIL fw_e4_gone: got %b/%h want 01/0", {rsp_hit[0], rsp_err[0]}, rsp_addr[47:0]); end
    n_checks++; if ({rsp_hit[1], rsp_err[1], rsp_addr[95:48]} !== {2'b10, 48'h0000_0601_0789})
      begin n_fail++; $display("FAIL fw_e0: got %b/%h want 10/000006010789", {rsp_hit[1], rsp_err[1]}, rsp_addr[95:48]); end
    req_valid = 2'b01; req_addr[47:0] = 48'h0000_0061_0000;
    step();
    n_checks++; if ({rsp_hit[0], rsp_err[0]} !== 2'b01) begin n_fail++; $display("FAIL fw_e1_gone: got %b want 01", {rsp_hit[0], rsp_err[0]}); end
    req_valid = '0;
    cfg_write(6, 36'h700, 36'h7FF, 36'h100, 1'b1, 1'b0);
    req_valid = 2'b01; req_addr[47:0] = 48'h0000_0070_0000;
    step();
    req_valid = '0;
    n_checks++; if ({rsp_hit[0], rsp_err[0]} !== 2'b01) begin n_fail++; $display("FAIL idx_oob: got %b want 01", {rsp_hit[0], rsp_err[0]}); end
    step();
  endtask

  task automatic test_bypass();
    logic [NC*AW-1:0] a;
    a = {16'($urandom), $urandom, 16'($urandom), $urandom};
    bypass = 1'b1; req_valid = 2'b11; req_addr = a; req_write = 2'($urandom);
    step();
    bypass = 1'b0; req_valid = '0;
    for (int c = 0; c < NC; c++) begin
      n_checks++; if ({rsp_valid[c], rsp_hit[c], rsp_err[c], rsp_addr[c*AW +: AW]} !== {3'b110, a[c*AW +: AW]})
        begin n_fail++; $display("FAIL bypass_rsp ch%0d: got %h want %h", c, {rsp_valid[c], rsp_hit[c], rsp_err[c], rsp_addr[c*AW +: AW]}, {3'b110, a[c*AW +: AW]}); end
      n_checks++; if ({hit_cnt[c*CW +: CW], miss_cnt[c*CW +: CW]} !== {4'(PERF ? e_hc[c] : 0), 4'(PERF ? e_mc[c] : 0)})
        begin n_fail++; $display("FAIL bypass_cnt ch%0d: got %h want %0d/%0d", c, {hit_cnt[c*CW +: CW], miss_cnt[c*CW +: CW]}, e_hc[c], e_mc[c]); end
    end
    step();
  endtask

  task automatic test_saturate();
    cfg_write(0, 36'h0, 36'hF_FFFF_FFFF, 36'h0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      req_valid = 2'b01; req_addr[47:0] = {16'($urandom), $urandom};
      step();
    end
    req_valid = '0;
    n_checks++; if (hit_cnt[3:0] !== (PERF ? 4'hF : 4'h0))
      begin n_fail++; $display("FAIL hit_sat: got %h want %h", hit_cnt[3:0], PERF ? 4'hF : 4'h0); end
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = 2'($urandom); req_write = 2'($urandom);
      for (int c = 0; c < NC; c++) req_addr[c*AW +: AW] = {12'h0, 24'($urandom_range(0, 63)), 12'($urandom)};
      rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      bypass = ($urandom_range(0, 15) == 0);
      cfg_flush = ($urandom_range(0, 31) == 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_idx = 3'($urandom);
      cfg_first = 36'($urandom_range(0, 63));
      cfg_last = cfg_first + 36'($urandom_range(0, 15));
      cfg_base = 36'({$urandom, $urandom});
      cfg_valid = ($urandom_range(0, 3) != 0);
      cfg_ro = 1'($urandom);
      #1;
      for (int c = 0; c < NC; c++) begin
        n_checks++; if (req_ready[c] !== (!e_v[c] || rsp_ready[c]))
          begin n_fail++; $display("FAIL rand_ready ch%0d cyc%0d: got %b want %b", c, k, req_ready[c], !e_v[c] || rsp_ready[c]); end
        if (e_v[c]) begin
          n_checks++; if ({rsp_valid[c], rsp_hit[c], rsp_err[c], rsp_addr[c*AW +: AW]} !== {1'b1, e_hit[c], e_err[c], e_addr[c]})
            begin n_fail++; $display("FAIL rand_rsp ch%0d cyc%0d: got %h want %h", c, k, {rsp_valid[c], rsp_hit[c], rsp_err[c], rsp_addr[c*AW +: AW]}, {1'b1, e_hit[c], e_err[c], e_addr[c]}); end
        end else begin
          n_checks++; if (rsp_valid[c] !== 1'b0) begin n_fail++; $display("FAIL rand_idle ch%0d cyc%0d: got %b want 0", c, k, rsp_valid[c]); end
        end
        n_checks++; if ({hit_cnt[c*CW +: CW], miss_cnt[c*CW +: CW]} !== {4'(PERF ? e_hc[c] : 0), 4'(PERF ? e_mc[c] : 0)})
          begin n_fail++; $display("FAIL rand_cnt ch%0d cyc%0d: got %h want %0d/%0d", c, k, {hit_cnt[c*CW +: CW], miss_cnt[c*CW +: CW]}, e_hc[c], e_mc[c]); end
      end
      step();
    end
    idle();
    step();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    test_reset();
    test_miss();
    test_translate();
    test_priority();
    test_back_to_back();
    test_flush_write();
    test_bypass();
    test_saturate();
    rst = 1'b1; step(); rst = 1'b0;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
